// File: rtl/mdu_iter_if.sv
// Handshake and result bus between the pipeline and the iterative multiply/divide unit.
interface mdu_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             stall;

  modport master (
    output start, funct, a, b, flush,
    input  busy, done, hi, lo, stall
  );

  modport slave (
    input  start, funct, a, b, flush,
    output busy, done, hi, lo, stall
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MIPS-style HI/LO unit: shift-add multiply and restoring divide, one bit per cycle,
// signs handled by magnitude conversion on entry and negation in a final FIX cycle.
module mdu_iter #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1
) (
  input logic     clk,
  input logic     rst,
  mdu_iter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // product upper half / partial remainder
  logic [WIDTH-1:0] wrk_q, wrk_d;   // multiplier shifting out / dividend in, quotient out
  logic [WIDTH-1:0] opd_q, opd_d;   // multiplicand / divisor magnitude
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, done_q, done_d;

  logic             is_mul, is_div, is_mthi, is_mtlo, op_signed, div_zero;
  logic             a_neg, b_neg, calc_last;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_trial;
  logic [WIDTH-1:0] div_rem, quo_fix, rem_fix;
  logic             div_ge;
  logic [PW-1:0]    prod, prod_fix;

  // Operation decode and entry magnitudes; divide-by-zero stays on the raw unsigned path
  always_comb begin
    is_mul    = (bus.funct == 6'b011000) || (bus.funct == 6'b011001);
    is_div    = (bus.funct == 6'b011010) || (bus.funct == 6'b011011);
    is_mthi   = (bus.funct == 6'b010001);
    is_mtlo   = (bus.funct == 6'b010011);
    op_signed = SIGNED_EN && !bus.funct[0];
    div_zero  = is_div && (bus.b == '0);
    a_neg     = op_signed && !div_zero && bus.a[WIDTH-1];
    b_neg     = op_signed && !div_zero && bus.b[WIDTH-1];
    a_mag     = a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
    b_mag     = b_neg ? (~bus.b + WIDTH'(1)) : bus.b;
  end

  // One iteration of each algorithm plus the sign fix-up of the finished result
  always_comb begin
    calc_last = (cnt_q == CNT_W'(WIDTH - 1));
    mul_sum   = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opd_q} : '0);
    div_trial = {acc_q, wrk_q[WIDTH-1]};
    div_ge    = (div_trial >= {1'b0, opd_q});
    div_rem   = div_trial[WIDTH-1:0] - opd_q;
    prod      = {acc_q, wrk_q};
    prod_fix  = neg_q ? (~prod + PW'(1)) : prod;
    quo_fix   = neg_q ? (~wrk_q + WIDTH'(1)) : wrk_q;
    rem_fix   = rneg_q ? (~acc_q + WIDTH'(1)) : acc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.start && (is_mul || is_div)) state_d = CALC;
        CALC:    if (calc_last) state_d = FIX;
        FIX:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    wrk_d  = wrk_q;
    opd_d  = opd_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    div_d  = div_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    done_d = 1'b0;
    if (!bus.flush) begin
      case (state_q)
        IDLE: begin
          if (bus.start && is_mthi) begin
            hi_d   = bus.a;
            done_d = 1'b1;
          end
          if (bus.start && is_mtlo) begin
            lo_d   = bus.a;
            done_d = 1'b1;
          end
          if (bus.start && (is_mul || is_div)) begin
            cnt_d  = '0;
            acc_d  = '0;
            wrk_d  = is_div ? a_mag : b_mag;
            opd_d  = is_div ? b_mag : a_mag;
            div_d  = is_div;
            neg_d  = a_neg ^ b_neg;
            rneg_d = is_div && a_neg;
          end
        end
        CALC: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (div_q) begin
            acc_d = div_ge ? div_rem : div_trial[WIDTH-1:0];
            wrk_d = {wrk_q[WIDTH-2:0], div_ge};
          end else begin
            acc_d = mul_sum[WIDTH:1];
            wrk_d = {mul_sum[0], wrk_q[WIDTH-1:1]};
          end
        end
        FIX: begin
          done_d = 1'b1;
          if (div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[PW-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      wrk_q  <= '0;
      opd_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      wrk_q  <= wrk_d;
      opd_q  <= opd_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      done_q <= done_d;
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.stall = bus.start && (state_q != IDLE);

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter: WIDTH, default 32, operand and HI/LO width; supported values are even and at least 4.
REQ-002 Parameter: SIGNED_EN, default 1; when 0, MULT/DIV execute as MULTU/DIVU.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; sampled only while busy=0.
REQ-006 funct  input  6  operation select, sampled with start.
REQ-007 a  input  WIDTH  operand rs (dividend/multiplicand/MTHI/MTLO source).
REQ-008 b  input  WIDTH  operand rt (divisor/multiplier).
REQ-009 flush  input  1  abort in-flight operation (pipeline exception).
REQ-010 busy  output  1  operation in progress.
REQ-011 done  output  1  one-cycle pulse, HI/LO just updated.
REQ-012 hi  output  WIDTH  HI register.
REQ-013 lo  output  WIDTH  LO register.
REQ-014 stall  output  1  high when start=1 and busy=1 (pipeline must hold).

Function
REQ-015 Decode on start: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO; any other funct ignored (no state change, no busy, no done).
REQ-016 FSM states IDLE, CALC, FIX; IDLE->CALC on accepted MULT*/DIV*; CALC->FIX after exactly WIDTH CALC cycles; FIX->IDLE after one cycle.
REQ-017 busy=1 in CALC and FIX; 0 in IDLE.
REQ-018 Latency: start accepted at edge N; hi/lo updated and done=1 in cycle following edge N+WIDTH+1; busy falls same cycle done rises.
REQ-019 Start accepted while done=1 (back-to-back), busy rises next edge.
REQ-020 MTHI/MTLO: hi<=a (resp. lo<=a) at accepting edge; no busy; done=1 next cycle.
REQ-021 Start while busy: ignored, stall=1, in-flight operation unaffected.
REQ-022 Multiply: iterative shift-add on magnitudes, one multiplier bit per CALC cycle; {hi,lo} = full 2*WIDTH-bit product.
REQ-023 Signed multiply: operand magnitudes taken in IDLE; FIX negates 2*WIDTH product if sign(a) xor sign(b).
REQ-024 Divide: restoring, one quotient bit per CALC cycle; lo=quotient, hi=remainder.
REQ-025 Signed divide: quotient truncates toward zero; remainder takes sign of dividend.
REQ-026 Divide by zero (b=0): lo=all ones, hi=a (unsigned magnitude path, sign fix-up skipped), done as normal.
REQ-027 Signed overflow (a=most-negative, b=-1): lo=a, hi=0, no trap.
REQ-028 flush=1 in any state: FSM->IDLE next edge, hi/lo unchanged, done=0; flush with start in IDLE: start ignored.
REQ-029 hi/lo change only at FIX completion, MTHI/MTLO, or reset; never mid-CALC.
REQ-030 Internal accumulator/remainder width WIDTH+1 for divide, 2*WIDTH for multiply; no carry loss.

Reset
REQ-031 rst=1 at edge: state IDLE, hi=0, lo=0, busy=0, done=0, internal counters and operand registers cleared.
REQ-032 rst overrides start and flush; rst mid-CALC abandons operation, no done pulse.
REQ-033 stall is combinational from start and busy, hence 0 throughout reset-held cycles after first edge.

Verification
REQ-034 WIDTH=32: MULT a=0xFFFFFFFE(-2), b=3 -> after 34 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse exactly once.
REQ-035 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007.
REQ-037 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 Start DIVU, assert flush at CALC cycle 10 -> busy low next cycle, hi/lo retain prior values, no done; then MTLO a=0x1234 -> lo=0x1234, done next cycle.
REQ-039 Start MULT, re-assert start at cycles 1-33 -> stall=1 each cycle, result unchanged; random regression vs reference model at WIDTH=8 and 32.
